// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative shift-add multiply / restoring divide sequencer feeding ACC and MR.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start, op, clr           start request (IDLE only), 0=multiply 1=divide, clear of held results
//   operand_a, operand_b     multiplicand/dividend, multiplier/divisor
//   busy, done               busy through ITER and DONE, one-cycle completion pulse
//   acc_we, mr_we            ACC/MR write strobes, coincident with done
//   acc_out, mr_out          product high/low half, or remainder/quotient
//   div_by_zero              set with done when a divide had a zero divisor
// Build option: define DIV_SEQ_DIV_EN to include the divider; otherwise op is ignored.
module mul_div_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             clr,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             acc_we,
  output logic             mr_we,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] m, q, a, nxt_a, nxt_q, mul_a, mul_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] sum;
  // The carry of A+M is shifted straight back into A, so it never needs its own register.
  always_comb begin
    sum = {1'b0, a} + (q[0] ? {1'b0, m} : '0);
    mul_a = sum[WIDTH:1];
    mul_q = {sum[0], q[WIDTH-1:1]};
  end
`ifdef DIV_SEQ_DIV_EN
  logic is_div;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] div_a, div_q;
  // The shifted partial remainder needs WIDTH+1 bits; an extra top bit serves as the borrow.
  always_comb begin
    diff = {1'b0, a, q[WIDTH-1]} - {2'b00, m};
    div_a = diff[WIDTH+1] ? {a[WIDTH-2:0], q[WIDTH-1]} : diff[WIDTH-1:0];
    div_q = {q[WIDTH-2:0], ~diff[WIDTH+1]};
    nxt_a = is_div ? div_a : mul_a;
    nxt_q = is_div ? div_q : mul_q;
  end
`else
  logic unused_op;
  assign unused_op = op;
  assign div_by_zero = 1'b0;
  always_comb begin
    nxt_a = mul_a;
    nxt_q = mul_q;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      m <= '0;
      q <= '0;
      a <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      acc_we <= 1'b0;
      mr_we <= 1'b0;
      acc_out <= '0;
      mr_out <= '0;
`ifdef DIV_SEQ_DIV_EN
      is_div <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          acc_we <= 1'b0;
          mr_we <= 1'b0;
          if (clr) begin
            acc_out <= '0;
            mr_out <= '0;
`ifdef DIV_SEQ_DIV_EN
            div_by_zero <= 1'b0;
`endif
          end
          if (start) begin
            m <= operand_b;
            q <= operand_a;
            a <= '0;
            cnt <= '0;
            busy <= 1'b1;
            state <= ITER;
`ifdef DIV_SEQ_DIV_EN
            is_div <= op;
            div_by_zero <= 1'b0;
            if (op && operand_b == '0) begin
              state <= DONE;
              done <= 1'b1;
              acc_we <= 1'b1;
              mr_we <= 1'b1;
              acc_out <= operand_a;
              mr_out <= '1;
              div_by_zero <= 1'b1;
            end
`endif
          end
        end
        ITER: begin
          a <= nxt_a;
          q <= nxt_q;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            done <= 1'b1;
            acc_we <= 1'b1;
            mr_we <= 1'b1;
            acc_out <= nxt_a;
            mr_out <= nxt_q;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
          acc_we <= 1'b0;
          mr_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
